bcd_convert_param: RTL and testbench

BCD_CONVERT_PARAM -- requirements
Module: bcd_convert_param

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_add3_digit.sv | 16 +
 rtl/bcd_convert_param.sv | 161 ++++++++++++++++
 tb/tb_bcd_convert_param.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the binary-to-BCD converter.
package bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest digit count whose decimal range covers every BIN_W-bit unsigned value
    function automatic int unsigned min_digits(input int unsigned bin_w);
        longint unsigned max_val;
        longint unsigned pow10;
        int unsigned     d;
        max_val = (64'd1 << bin_w) - 64'd1;
        pow10   = 64'd1;
        d       = 0;
        while (pow10 <= max_val) begin
            pow10 = pow10 * 64'd10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module bcd_add3_digit (
    input  logic [3:0] d_in,
    output logic [3:0] d_out_c
);

    // Conditional +3 correction
    always_comb begin
        d_out_c = d_in;
        if (d_in >= 4'd5) begin
            d_out_c = d_in + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_convert_param.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// Optional build macro BCD_SIGNED_EN: treat bin_in as two's complement,
// convert its magnitude and report the sign on bcd_sign.
module bcd_convert_param
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 12,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef BCD_SIGNED_EN
    output logic                  bcd_sign,
`endif
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    // Parameter legality is enforced at elaboration
    generate
        if (BIN_W < 4 || BIN_W > 32) begin : g_bad_bin_w
            $error("bcd_convert_param: BIN_W must be in 4..32");
        end
        if (DIGITS < min_digits(BIN_W)) begin : g_bad_digits
            $error("bcd_convert_param: DIGITS too small for BIN_W");
        end
    endgenerate

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    operand_q, operand_d;
    logic [BCD_W-1:0]    scratch_q, scratch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [BCD_W-1:0]    bcd_out_q, bcd_out_d;
    logic [BCD_W-1:0]    adj_c;
    logic [BIN_W-1:0]    capture_c;

    // Per-digit +3 correction on the current scratch
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .d_in    (scratch_q[4*g +: 4]),
            .d_out_c (adj_c[4*g +: 4])
        );
    end

`ifdef BCD_SIGNED_EN
    logic sign_in_c;
    logic sign_q, sign_d;
    logic bcd_sign_q, bcd_sign_d;

    // Magnitude of the two's complement operand; the most negative value maps to 2^(BIN_W-1)
    always_comb begin
        sign_in_c = bin_in[BIN_W-1];
        capture_c = bin_in;
        if (sign_in_c) begin
            capture_c = BIN_W'((~bin_in) + BIN_W'(1));
        end
    end
`else
    // Unsigned operand is converted as-is
    always_comb begin
        capture_c = bin_in;
    end
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
`ifdef BCD_SIGNED_EN
        sign_d    = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    operand_d = capture_c;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
`ifdef BCD_SIGNED_EN
                    sign_d    = sign_in_c;
`endif
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = (adj_c << 1) | BCD_W'(operand_q[BIN_W-1]);
                operand_d = operand_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        bcd_out_d   = (state_d == DONE) ? scratch_d : '0;
`ifdef BCD_SIGNED_EN
        bcd_sign_d  = (state_d == DONE) ? sign_d : 1'b0;
`endif
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            operand_q   <= '0;
            scratch_q   <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            bcd_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            operand_q   <= operand_d;
            scratch_q   <= scratch_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            bcd_out_q   <= bcd_out_d;
        end
    end

`ifdef BCD_SIGNED_EN
    // Sign capture and registered sign output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q     <= 1'b0;
            bcd_sign_q <= 1'b0;
        end else begin
            sign_q     <= sign_d;
            bcd_sign_q <= bcd_sign_d;
        end
    end

    assign bcd_sign = bcd_sign_q;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_out_q;

endmodule

// File: tb/tb_bcd_convert_param.sv
// Directed and randomized checks of bcd_convert_param against an arithmetic model.
// Works with or without BCD_SIGNED_EN defined.
module tb_bcd_convert_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [11:0] bin_in = '0;
    logic [15:0] bcd_out;
    logic        sgn12;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
    logic [15:0] bin_in16 = '0;
    logic [19:0] bcd_out16;
    logic        sgn16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef BCD_SIGNED_EN
    logic bcd_sign, bcd_sign16;
    assign sgn12 = bcd_sign;
    assign sgn16 = bcd_sign16;
`else
    assign sgn12 = 1'b0;
    assign sgn16 = 1'b0;
`endif

    bcd_convert_param #(.BIN_W(12), .DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BCD_SIGNED_EN
        .bcd_sign  (bcd_sign),
`endif
        .bcd_out   (bcd_out)
    );

    bcd_convert_param #(.BIN_W(16), .DIGITS(5)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .bin_in    (bin_in16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
`ifdef BCD_SIGNED_EN
        .bcd_sign  (bcd_sign16),
`endif
        .bcd_out   (bcd_out16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits of the value (magnitude in signed builds), sign above the digits
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int w, input int digits);
        longint unsigned mag;
        logic [63:0]     r;
        logic            neg;
        mag = v;
        neg = 1'b0;
`ifdef BCD_SIGNED_EN
        if (v >= (64'd1 << (w - 1))) begin
            neg = 1'b1;
            mag = (64'd1 << w) - v;
        end
`endif
        r = '0;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        r[4*digits] = neg;
        return r;
    endfunction

    // One full transaction on the 12-bit instance; hold = cycles of out_ready=0 in DONE
    task automatic run12(input logic [11:0] v, input logic [16:0] exp, input int hold, input string tag);
        int   edges;
        bit   quiet;
        logic [16:0] held;
        @(negedge clk);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        bin_in    = v;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        bin_in   = 12'($urandom);
        edges = 0;
        quiet = 1'b1;
        while (out_valid !== 1'b1 && edges < 64) begin
            if (in_ready !== 1'b0 || bcd_out !== 16'h0) quiet = 1'b0;
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            bin_in   = 12'($urandom);
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        chk({tag, "_conv_quiet"}, 64'(quiet), 64'd1);
        chk({tag, "_latency"}, 64'(edges), 64'd12);
        chk({tag, "_result"}, 64'({sgn12, bcd_out}), 64'(exp));
        held = {sgn12, bcd_out};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold"}, 64'({out_valid, in_ready, sgn12, bcd_out}), 64'({2'b10, held}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_release"}, 64'({in_ready, out_valid, sgn12, bcd_out}), 64'({2'b10, 17'h0}));
    endtask

    // One transaction on the 16-bit instance with out_ready held high
    task automatic run16(input logic [15:0] v, input logic [20:0] exp, input string tag);
        int edges;
        @(negedge clk);
        bin_in16    = v;
        in_valid16  = 1'b1;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        edges = 0;
        while (out_valid16 !== 1'b1 && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, "_latency16"}, 64'(edges), 64'd16);
        chk({tag, "_result16"}, 64'({sgn16, bcd_out16}), 64'(exp));
        @(posedge clk); #1;
        chk({tag, "_idle16"}, 64'({in_ready16, out_valid16, bcd_out16}), 64'({2'b10, 20'h0}));
    endtask

    initial begin
        bit seen;
        logic [11:0] r;
        logic [15:0] r16;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'({in_ready, out_valid, sgn12, bcd_out}), 64'({2'b10, 17'h0}));
        chk("reset_state16", 64'({in_ready16, out_valid16, sgn16, bcd_out16}), 64'({2'b10, 21'h0}));
        @(negedge clk);
        rst_n = 1'b1;

        run12(12'd0, 17'h00000, 0, "zero");
`ifdef BCD_SIGNED_EN
        run12(12'h800, 17'h12048, 0, "most_neg");
        run12(12'hFFF, 17'h10001, 0, "minus_one");
`else
        run12(12'd4095, 17'h04095, 0, "max");
`endif
        run12(12'd1, 17'h00001, 0, "one");
        run12(12'd11, 17'h00011, 0, "eleven");
        run12(12'd21, 17'h00021, 0, "twenty_one");
        run12(12'd1234, 17'h01234, 5, "backpressure");

        // Reset at the 6th CONV edge discards the conversion
        @(negedge clk);
        bin_in   = 12'd999;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_reset", 64'({in_ready, out_valid, sgn12, bcd_out}), 64'({2'b10, 17'h0}));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        chk("no_valid_after_reset", 64'(seen), 64'd0);
        run12(12'h7, 17'h00007, 0, "after_reset");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            r = 12'($urandom);
            run12(r, 17'(ref_bcd(64'(r), 12, 4)), int'($urandom_range(0, 3)), "rand");
        end

`ifdef BCD_SIGNED_EN
        run16(16'hFFFF, 21'h100001, "max16");
`else
        run16(16'hFFFF, 21'h065535, "max16");
`endif
        for (int i = 0; i < 4; i++) begin
            r16 = 16'($urandom);
            run16(r16, 21'(ref_bcd(64'(r16), 16, 5)), "rand16");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
